// File: rtl/fp_align_shift.sv
// -----------------------------------------------------------------------------
// fp_align_shift
//
// Exponent alignment stage for a floating-point adder. It accepts an operand
// pair, picks the larger operand and right-shifts the smaller mantissa by the
// exponent difference. The bits shifted out are kept as guard, round and
// sticky for later rounding. The shift is iterative, one bit per cycle. When
// the difference is 0 or at least 27 the result is produced directly.
//
// Optional build macro:
//   FP_ALIGN_FAST_EN - shift two bits per cycle while two or more remain.
//                      This roughly halves the latency. The final mantissa
//                      and guard/round/sticky bits are the same as in the
//                      default 1-bit-per-cycle build.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      operand pair valid (accepted only while idle)
//   in_ready      block is idle and can accept an operand pair
//   man_a/man_b   24-bit mantissas, hidden bit at [23]
//   exp_a/exp_b   8-bit biased exponents
//   out_valid     aligned result valid (held until out_ready)
//   out_ready     downstream accepts the result
//   man_big       mantissa of the larger operand, unshifted
//   man_small_al  smaller mantissa after the alignment shift
//   exp_out       larger (common) exponent
//   grs           {guard, round, sticky} shifted out of man_small_al
//   swap          1 when operand b was chosen as the larger operand
// -----------------------------------------------------------------------------
module fp_align_shift (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] man_a,
    input  logic [23:0] man_b,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] man_big,
    output logic [23:0] man_small_al,
    output logic [7:0]  exp_out,
    output logic [2:0]  grs,
    output logic        swap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A difference of 27 or more leaves only sticky information: all 24
    // mantissa bits, plus guard and round, have been shifted out.
    localparam logic [7:0] CLAMP_DIFF = 8'd27;

    state_t      state_reg;
    logic [23:0] man_big_reg;
    logic [23:0] man_small_reg;
    logic [7:0]  exp_reg;
    logic [7:0]  count_reg;
    logic        guard_reg;
    logic        round_reg;
    logic        sticky_reg;
    logic        swap_reg;

    // Operand ordering, evaluated on the raw inputs for use at accept.
    logic        a_larger;
    logic [7:0]  exp_big_in;
    logic [7:0]  exp_small_in;
    logic [23:0] man_big_in;
    logic [23:0] man_small_in;
    logic [7:0]  diff_in;

    always_comb begin
        a_larger     = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a >= man_b));
        exp_big_in   = a_larger ? exp_a : exp_b;
        exp_small_in = a_larger ? exp_b : exp_a;
        man_big_in   = a_larger ? man_a : man_b;
        man_small_in = a_larger ? man_b : man_a;
        // The larger exponent comes first, so this never wraps.
        diff_in      = exp_big_in - exp_small_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            man_big_reg   <= '0;
            man_small_reg <= '0;
            exp_reg       <= '0;
            count_reg     <= '0;
            guard_reg     <= 1'b0;
            round_reg     <= 1'b0;
            sticky_reg    <= 1'b0;
            swap_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        man_big_reg <= man_big_in;
                        exp_reg     <= exp_big_in;
                        swap_reg    <= ~a_larger;
                        count_reg   <= diff_in;
                        guard_reg   <= 1'b0;
                        round_reg   <= 1'b0;
                        if (diff_in == 8'd0) begin
                            man_small_reg <= man_small_in;
                            sticky_reg    <= 1'b0;
                            state_reg     <= DONE;
                        end else if (diff_in >= CLAMP_DIFF) begin
                            man_small_reg <= '0;
                            sticky_reg    <= |man_small_in;
                            state_reg     <= DONE;
                        end else begin
                            man_small_reg <= man_small_in;
                            sticky_reg    <= 1'b0;
                            state_reg     <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
`ifdef FP_ALIGN_FAST_EN
                    if (count_reg >= 8'd2) begin
                        // Two-bit step. Both bits shifted out become the new
                        // guard and round. The old guard and round both fall
                        // into sticky.
                        man_small_reg <= {2'b00, man_small_reg[23:2]};
                        guard_reg     <= man_small_reg[1];
                        round_reg     <= man_small_reg[0];
                        sticky_reg    <= sticky_reg | guard_reg | round_reg;
                        count_reg     <= count_reg - 8'd2;
                        if (count_reg == 8'd2) begin
                            state_reg <= DONE;
                        end
                    end else begin
                        man_small_reg <= {1'b0, man_small_reg[23:1]};
                        guard_reg     <= man_small_reg[0];
                        round_reg     <= guard_reg;
                        sticky_reg    <= sticky_reg | round_reg;
                        count_reg     <= count_reg - 8'd1;
                        state_reg     <= DONE;
                    end
`else
                    man_small_reg <= {1'b0, man_small_reg[23:1]};
                    guard_reg     <= man_small_reg[0];
                    round_reg     <= guard_reg;
                    sticky_reg    <= sticky_reg | round_reg;
                    count_reg     <= count_reg - 8'd1;
                    // This step consumes the last remaining shift.
                    if (count_reg == 8'd1) begin
                        state_reg <= DONE;
                    end
`endif
                end

                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = (state_reg == IDLE);
    assign out_valid    = (state_reg == DONE);
    assign man_big      = man_big_reg;
    assign man_small_al = man_small_reg;
    assign exp_out      = exp_reg;
    assign grs          = {guard_reg, round_reg, sticky_reg};
    assign swap         = swap_reg;

endmodule
